// File: rtl/instrumentation_trip_latch.sv
// Per-channel instrumentation trip stage. Each channel compares its sensor sample against its
// setpoint, debounces the exceed condition over consecutive valid samples, and latches a trip
// that only an operator reset (or a move to bypass) clears. All outputs are registered.
// Channel 0 occupies the most significant slice of every bus.
module instrumentation_trip_latch #(
  parameter int unsigned         NChannels   = 3,
  parameter int unsigned         W           = 32,
  parameter int unsigned         Debounce    = 3,
  parameter logic [NChannels-1:0] LowTripMask = 3'b001
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sample_valid_i,
  input  logic [NChannels*W-1:0] vals_i,
  input  logic [NChannels*W-1:0] setpoints_i,
  input  logic [NChannels*2-1:0] mode_i,
  input  logic                   trip_reset_i,
  output logic [NChannels-1:0]   raw_exceed_o,
  output logic [NChannels-1:0]   trip_o,
  output logic                   trip_valid_o
);

  localparam int unsigned    CntW   = (Debounce < 1) ? 1 : $clog2(Debounce + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(Debounce);

  localparam logic [1:0] ModeBypass  = 2'd0;
  localparam logic [1:0] ModeOperate = 2'd1;
  localparam logic [1:0] ModeManual  = 2'd2;
  localparam logic [1:0] ModeBypass3 = 2'd3;

  // All per-channel state is indexed by bus bit position, so channel ch lives at NChannels-1-ch.
  logic [NChannels-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NChannels-1:0]           raw_q, raw_d;
  logic [NChannels-1:0]           trip_q, trip_d;
  logic                           trip_valid_q, trip_valid_d;

  logic [W-1:0] v, s;
  logic [1:0]   m;
  logic         exceed;
  logic         bypass;

  // Next-state: comparison, debounce count, then trip clear/set with set winning over reset
  // and bypass overriding everything.
  always_comb begin
    cnt_d        = cnt_q;
    raw_d        = raw_q;
    trip_d       = trip_q;
    trip_valid_d = sample_valid_i;
    v            = '0;
    s            = '0;
    m            = ModeBypass;
    exceed       = 1'b0;
    bypass       = 1'b1;
    for (int unsigned b = 0; b < NChannels; b++) begin
      v      = vals_i[W*b +: W];
      s      = setpoints_i[W*b +: W];
      m      = mode_i[2*b +: 2];
      exceed = LowTripMask[b] ? (v < s) : (v > s);
      bypass = (m == ModeBypass) || (m == ModeBypass3);

      if (sample_valid_i) begin
        raw_d[b] = exceed;
        if (!exceed) begin
          cnt_d[b] = '0;
        end else if (cnt_q[b] != CntMax) begin
          cnt_d[b] = cnt_q[b] + 1'b1;
        end
      end
      if (bypass) begin
        cnt_d[b] = '0;
      end

      // A channel still exceeding, or held in manual trip, ignores the operator reset.
      if (trip_reset_i && (cnt_d[b] == '0) && (m != ModeManual)) begin
        trip_d[b] = 1'b0;
      end
      if (sample_valid_i && (m == ModeOperate) && (cnt_d[b] == CntMax)) begin
        trip_d[b] = 1'b1;
      end
      if (sample_valid_i && (m == ModeManual)) begin
        trip_d[b] = 1'b1;
      end
      if (bypass) begin
        trip_d[b] = 1'b0;
      end
    end
  end

  // State registers; asynchronous reset discards any partial debounce count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      raw_q        <= '0;
      trip_q       <= '0;
      trip_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      raw_q        <= raw_d;
      trip_q       <= trip_d;
      trip_valid_q <= trip_valid_d;
    end
  end

  assign raw_exceed_o = raw_q;
  assign trip_o       = trip_q;
  assign trip_valid_o = trip_valid_q;

endmodule

// File: tb/tb_instrumentation_trip_latch.sv
// Bench for instrumentation_trip_latch: directed vector table on the default configuration and
// a random scoreboard run on a 4-channel, Debounce = 1 configuration.
module tb_instrumentation_trip_latch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default configuration instance.
  logic        a_valid;
  logic [95:0] a_vals, a_sps;
  logic [5:0]  a_mode;
  logic        a_tr;
  logic [2:0]  a_raw, a_trip;
  logic        a_tv;

  // NChannels = 4, W = 16, Debounce = 1, LowTripMask = 4'b0101 instance.
  logic        b_valid;
  logic [63:0] b_vals, b_sps;
  logic [7:0]  b_mode;
  logic        b_tr;
  logic [3:0]  b_raw, b_trip;
  logic        b_tv;

  instrumentation_trip_latch dut_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_valid_i(a_valid),
    .vals_i        (a_vals),
    .setpoints_i   (a_sps),
    .mode_i        (a_mode),
    .trip_reset_i  (a_tr),
    .raw_exceed_o  (a_raw),
    .trip_o        (a_trip),
    .trip_valid_o  (a_tv)
  );

  instrumentation_trip_latch #(
    .NChannels  (4),
    .W          (16),
    .Debounce   (1),
    .LowTripMask(4'b0101)
  ) dut_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_valid_i(b_valid),
    .vals_i        (b_vals),
    .setpoints_i   (b_sps),
    .mode_i        (b_mode),
    .trip_reset_i  (b_tr),
    .raw_exceed_o  (b_raw),
    .trip_o        (b_trip),
    .trip_valid_o  (b_tv)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [95:0] vals;
    logic [95:0] sps;
    logic [5:0]  md;
    logic        tr;
    logic [2:0]  er;
    logic [2:0]  et;
    logic        etv;
  } vec_t;

  typedef struct {
    logic [2:0] er;
    logic [2:0] et;
    logic       etv;
    int         id;
  } exp_a_t;

  typedef struct {
    logic [3:0] er;
    logic [3:0] et;
    logic       etv;
  } exp_b_t;

  vec_t   vecs[$];
  exp_a_t sb_a[$];
  exp_b_t sb_b[$];
  int     vec_id = 0;

  localparam logic [5:0] Op    = 6'b01_01_01;
  localparam logic [5:0] Man0  = 6'b10_01_01;
  localparam logic [5:0] Byp1  = 6'b01_00_01;
  localparam logic [5:0] Byp13 = 6'b01_11_01;
  localparam logic [5:0] ManAl = 6'b10_10_10;

  // Setpoints are fixed at ch0 = 100, ch1 = 100, ch2 = 50 (ch2 is the low-tripping channel).
  function automatic vec_t mk(input logic v, input logic [31:0] c0, input logic [31:0] c1,
                              input logic [31:0] c2, input logic [5:0] md, input logic tr,
                              input logic [2:0] er, input logic [2:0] et);
    vec_t x;
    x.v    = v;
    x.vals = {c0, c1, c2};
    x.sps  = {32'd100, 32'd100, 32'd50};
    x.md   = md;
    x.tr   = tr;
    x.er   = er;
    x.et   = et;
    x.etv  = v;
    return x;
  endfunction

  task automatic run_vecs();
    exp_a_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      a_valid = vecs[i].v;
      a_vals  = vecs[i].vals;
      a_sps   = vecs[i].sps;
      a_mode  = vecs[i].md;
      a_tr    = vecs[i].tr;
      e.er  = vecs[i].er;
      e.et  = vecs[i].et;
      e.etv = vecs[i].etv;
      e.id  = vec_id++;
      sb_a.push_back(e);
      @(posedge clk);
      #1;
      e = sb_a.pop_front();
      chk($sformatf("vec%0d.raw_exceed", e.id), 32'(a_raw), 32'(e.er));
      chk($sformatf("vec%0d.trip", e.id), 32'(a_trip), 32'(e.et));
      chk($sformatf("vec%0d.trip_valid", e.id), 32'(a_tv), 32'(e.etv));
    end
    vecs.delete();
  endtask

  task automatic idle_a();
    a_valid = 1'b0;
    a_vals  = '0;
    a_sps   = '0;
    a_mode  = Op;
    a_tr    = 1'b0;
  endtask

  // Reference model state for the 4-channel instance.
  logic [3:0] m_raw, m_trip, m_cnt;
  int         m_tv_cnt, d_tv_cnt;

  task automatic run_random(input int cycles);
    exp_b_t     e;
    logic [15:0] v, s;
    logic [1:0]  md;
    logic        ex, byp;
    int          b;
    int          r;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      b_valid = ($urandom_range(0, 3) != 0);
      for (int ch = 0; ch < 4; ch++) begin
        b_vals[16*(3-ch) +: 16] = 16'($urandom_range(0, 7));
        b_sps[16*(3-ch) +: 16]  = 16'($urandom_range(0, 7));
        r = int'($urandom_range(0, 9));
        b_mode[2*(3-ch) +: 2] = (r < 6) ? 2'd1 : (r == 6) ? 2'd2 : (r == 7) ? 2'd0 :
                                (r == 8) ? 2'd3 : 2'd1;
      end
      b_tr = !b_valid && ($urandom_range(0, 2) == 0);

      for (int ch = 0; ch < 4; ch++) begin
        b   = 3 - ch;
        v   = b_vals[16*b +: 16];
        s   = b_sps[16*b +: 16];
        md  = b_mode[2*b +: 2];
        // Channels 1 and 3 trip low with mask 4'b0101.
        ex  = (ch == 1 || ch == 3) ? (v < s) : (v > s);
        byp = (md == 2'd0) || (md == 2'd3);
        if (b_valid) begin
          m_raw[b] = ex;
          m_cnt[b] = ex;
        end
        if (byp) m_cnt[b] = 1'b0;
        if (b_tr && !m_cnt[b] && md != 2'd2) m_trip[b] = 1'b0;
        if (b_valid && ((md == 2'd1 && m_cnt[b]) || md == 2'd2)) m_trip[b] = 1'b1;
        if (byp) m_trip[b] = 1'b0;
      end
      if (b_valid) m_tv_cnt++;
      e.er  = m_raw;
      e.et  = m_trip;
      e.etv = b_valid;
      sb_b.push_back(e);

      @(posedge clk);
      #1;
      e = sb_b.pop_front();
      if (b_tv) d_tv_cnt++;
      chk($sformatf("rnd%0d.raw_exceed", n), 32'(b_raw), 32'(e.er));
      chk($sformatf("rnd%0d.trip", n), 32'(b_trip), 32'(e.et));
      chk($sformatf("rnd%0d.trip_valid", n), 32'(b_tv), 32'(e.etv));
    end
  endtask

  initial begin
    idle_a();
    b_valid = 1'b0;
    b_vals  = '0;
    b_sps   = '0;
    b_mode  = '0;
    b_tr    = 1'b0;
    m_raw   = '0;
    m_trip  = '0;
    m_cnt   = '0;
    m_tv_cnt = 0;
    d_tv_cnt = 0;

    // Power-on reset state.
    #12;
    chk("reset.raw_exceed", 32'(a_raw), 32'd0);
    chk("reset.trip", 32'(a_trip), 32'd0);
    chk("reset.trip_valid", 32'(a_tv), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Channel 0 debounce with gaps, then trip reset after it stops exceeding.
    vecs.push_back(mk(1, 101, 0, 100, Op, 0, 3'b100, 3'b000));
    vecs.push_back(mk(0, 101, 0, 100, Op, 0, 3'b100, 3'b000));
    vecs.push_back(mk(1, 101, 0, 100, Op, 0, 3'b100, 3'b000));
    vecs.push_back(mk(0, 101, 0, 100, Op, 0, 3'b100, 3'b000));
    vecs.push_back(mk(1, 101, 0, 100, Op, 0, 3'b100, 3'b100));
    vecs.push_back(mk(1,   0, 0, 100, Op, 0, 3'b000, 3'b100));
    vecs.push_back(mk(0,   0, 0, 100, Op, 1, 3'b000, 3'b000));
    // Equality breaks the run: 2 exceed, 1 equal, 2 exceed never trips.
    vecs.push_back(mk(1, 101, 0, 100, Op, 0, 3'b100, 3'b000));
    vecs.push_back(mk(1, 101, 0, 100, Op, 0, 3'b100, 3'b000));
    vecs.push_back(mk(1, 100, 0, 100, Op, 0, 3'b000, 3'b000));
    vecs.push_back(mk(1, 101, 0, 100, Op, 0, 3'b100, 3'b000));
    vecs.push_back(mk(1, 101, 0, 100, Op, 0, 3'b100, 3'b000));
    vecs.push_back(mk(1,   0, 0, 100, Op, 0, 3'b000, 3'b000));
    // Low-trip channel 2.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 0, 0, 49, Op, 0, 3'b001, (k == 2) ? 3'b001 : 3'b000));
    vecs.push_back(mk(1, 0, 0, 100, Op, 0, 3'b000, 3'b001));
    vecs.push_back(mk(0, 0, 0, 100, Op, 1, 3'b000, 3'b000));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1, 0, 0, 51, Op, 0, 3'b000, 3'b000));
    // Channel 1 latch and operator reset.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(1, 0, 200, 100, Op, 0, 3'b010, (k == 2) ? 3'b010 : 3'b000));
    vecs.push_back(mk(0, 0, 200, 100, Op, 1, 3'b010, 3'b010));
    vecs.push_back(mk(1, 0, 200, 100, Op, 1, 3'b010, 3'b010));
    vecs.push_back(mk(1, 0, 100, 100, Op, 0, 3'b000, 3'b010));
    vecs.push_back(mk(0, 0, 100, 100, Op, 1, 3'b000, 3'b000));
    vecs.push_back(mk(1, 0, 200, 100, Op, 0, 3'b010, 3'b000));
    vecs.push_back(mk(1, 0, 200, 100, Op, 0, 3'b010, 3'b000));
    vecs.push_back(mk(1, 0, 200, 100, Op, 1, 3'b010, 3'b010));
    vecs.push_back(mk(1, 0,   0, 100, Op, 0, 3'b000, 3'b010));
    vecs.push_back(mk(0, 0,   0, 100, Op, 1, 3'b000, 3'b000));
    // Manual trip on channel 0 only acts on valid samples and ignores trip_reset.
    vecs.push_back(mk(0, 0, 0, 100, Man0, 0, 3'b000, 3'b000));
    vecs.push_back(mk(1, 0, 0, 100, Man0, 0, 3'b000, 3'b100));
    vecs.push_back(mk(0, 0, 0, 100, Man0, 1, 3'b000, 3'b100));
    vecs.push_back(mk(0, 0, 0, 100, Op,   1, 3'b000, 3'b000));
    // Bypass on channel 1 (modes 0 and 3) with a large excursion.
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 0, 5000, 100, Byp1, 0, 3'b010, 3'b000));
    vecs.push_back(mk(1, 0, 5000, 100, Byp13, 0, 3'b010, 3'b000));
    // Trip channel 1 again, then drop it to bypass on an idle cycle.
    vecs.push_back(mk(1, 0, 200, 100, Op, 0, 3'b010, 3'b000));
    vecs.push_back(mk(1, 0, 200, 100, Op, 0, 3'b010, 3'b000));
    vecs.push_back(mk(1, 0, 200, 100, Op, 0, 3'b010, 3'b010));
    vecs.push_back(mk(0, 0, 200, 100, Byp1, 0, 3'b010, 3'b000));
    // All channels manually tripped.
    vecs.push_back(mk(1, 0, 0, 100, ManAl, 0, 3'b000, 3'b111));
    run_vecs();

    // Asynchronous reset while the clock is high: outputs clear with no edge.
    rst_n = 1'b0;
    #1;
    chk("async_reset.raw_exceed", 32'(a_raw), 32'd0);
    chk("async_reset.trip", 32'(a_trip), 32'd0);
    chk("async_reset.trip_valid", 32'(a_tv), 32'd0);
    @(negedge clk);
    idle_a();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Count restarts after reset: third sample is the first to trip.
    vecs.push_back(mk(1, 101, 0, 100, Op, 0, 3'b100, 3'b000));
    vecs.push_back(mk(1, 101, 0, 100, Op, 0, 3'b100, 3'b000));
    vecs.push_back(mk(1, 101, 0, 100, Op, 0, 3'b100, 3'b100));
    run_vecs();

    @(negedge clk);
    idle_a();

    run_random(400);
    chk("rnd.trip_valid_pulses", 32'(d_tv_cnt), 32'(m_tv_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instrumentation_trip_latch.md
# instrumentation_trip_latch

Registered, parametrised instrumentation trip stage for the RTS channel path. Compares each channel's sensor sample against its setpoint, debounces the over- or under-limit condition over consecutive valid samples, and latches a per-channel trip that holds until an explicit operator reset. Sits between the sensor sampling front end and the voting logic. Extends the combinational per-channel trip comparison with:

- a configurable channel count, width, debounce depth and per-channel trip direction;
- trip latching with an operator reset.

## Interface

Parameters:

- NChannels, 3, number of instrumentation channels.
- W, 32, sample/setpoint width in bits (unsigned).
- Debounce, 3, consecutive exceeding samples required to trip (1..15).
- LowTripMask, 3'b001, bit `NChannels-1-ch` set means channel `ch` trips when value < setpoint; clear means it trips when value > setpoint. The default makes channel 2 low-tripping.

Ports:

- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_valid  in  1  vals is valid this cycle.
- vals  in  NChannels*W  sensor samples.
- setpoints  in  NChannels*W  trip setpoints.
- mode  in  NChannels*2  per-channel mode: 0 bypass, 1 operate, 2 manual trip, 3 treated as bypass.
- trip_reset  in  1  operator request to clear latched trips.
- raw_exceed  out  NChannels  registered comparison result of the last valid sample.
- trip  out  NChannels  latched per-channel trip.
- trip_valid  out  1  one-cycle pulse indicating trip/raw_exceed reflect a new sample.

Bit ordering for vals, setpoints, mode, raw_exceed and trip:

- Channel 0 is the most significant slice.
- Channel `ch` of vals occupies `[W*(NChannels-ch-1) +: W]`.
- Channel `ch` of trip is bit `NChannels-ch-1`.

## Operation

Per channel, evaluated only on cycles with sample_valid = 1:

- Comparison:
  - exceed = (v < sp) when the channel's LowTripMask bit is set, else (v > sp).
  - Comparisons are strict and unsigned; equality never exceeds.
- Count register, width clog2(Debounce+1):
  - exceed = 1 → cnt saturating increment, capped at Debounce.
  - exceed = 0 → cnt cleared to 0.
- Mode effects:
  - Bypass (0 or 3): cnt forced to 0, trip forced to 0, raw_exceed still updated.
  - Operate (1): trip set when the post-update cnt equals Debounce. Once set, trip stays 1 regardless of later samples.
  - Manual trip (2): trip set to 1 immediately, independent of cnt.

trip_reset, which is sampled every cycle whether or not sample_valid is high:

- Clears trip for each channel whose cnt is 0 and whose mode is not 2.
- A channel still exceeding (cnt > 0) or in manual trip keeps trip = 1.
- Simultaneous set and reset in one cycle (sample_valid with a new debounce completion, and trip_reset): set wins, and trip is 1.

Cycles without sample_valid:

- cnt and raw_exceed hold.
- trip changes only via trip_reset, or via a mode change to bypass.
- The mode-to-bypass clear applies every cycle.
- Manual trip applies only on sample_valid cycles.

## Timing

- Reset (rst_n low, asynchronous): raw_exceed = 0, trip = 0, trip_valid = 0, all cnt = 0. Outputs are held while rst_n is low. A reset mid-debounce discards partial counts.
- Latency: a sample presented with sample_valid at edge t produces raw_exceed, trip and trip_valid = 1 after edge t.
- trip_valid is 0 in any cycle following a cycle without sample_valid. Back-to-back valid samples give trip_valid high continuously.
- Time to trip in Operate with continuous exceeding samples: Debounce valid samples. Trip is visible one cycle after the Debounce-th sample.
- Gaps in sample_valid do not reset the count; only a non-exceeding valid sample does.
- No combinational path from inputs to outputs.

## Test plan

- Reset: rst_n low asserted mid-operation with trip = 3'b111 → all outputs 0 asynchronously, with no clock needed. After release, 2 exceeding samples do not trip (Debounce = 3).
- Debounce, channel 0 in operate: v = 101, sp = 100 for 3 valid samples, with gaps of sample_valid = 0 between them → trip[2] rises after the 3rd sample only. A sequence of 2 exceeding, 1 at v = 100 (equal), then 2 exceeding → no trip.
- Low-trip channel 2 in operate: v = 49, sp = 50 × 3 → trip[0] = 1. v = 51, sp = 50 × 5 → trip[0] stays 0.
- Latch and reset, channel 1 tripped:
  - trip_reset while still exceeding → trip holds 1.
  - One valid sample with v ≤ sp, then trip_reset → trip[1] clears the cycle after.
  - trip_reset in the same cycle as the 3rd exceeding sample → trip = 1.
- Modes: mode = 2 with v < sp → trip = 1 one cycle after a valid sample. mode = 0 or 3 with v ≫ sp × 10 → trip = 0, raw_exceed = 1. Switching a tripped channel to bypass → trip = 0 next cycle.
- Parametrisation: NChannels = 4, W = 16, Debounce = 1, LowTripMask = 4'b0101. Random vectors are checked against a reference model, including raw_exceed ordering and trip_valid pulse counts.
